// File: rtl/im_loader_ctrl.sv
// im_loader_ctrl: loads host words into instruction memory while holding the core in reset, then releases it.
module im_loader_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [AW:0]   i_wcount,
  input  logic          i_abort,
  input  logic          i_host_valid,
  input  logic [31:0]   i_host_data,
  output logic          o_host_ready,
  output logic [3:0]    o_im_wen,
  output logic [AW-1:0] o_im_addr,
  output logic [31:0]   o_im_wdata,
  output logic          o_core_rst_n,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;
  localparam logic [AW:0] MAXW = (AW+1)'(DEPTH);
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic wen_q, wen_d, drn_q, drn_d, done_q, done_d, err_q, err_d, crn_q, crn_d;
  logic start_ok, hs, last;
  assign start_ok = (i_wcount != '0) && (i_wcount <= MAXW);
  assign o_host_ready = state_q == LOAD;
  assign o_busy = (state_q == LOAD) || (state_q == DRAIN);
  // abort beats a coincident handshake: the word is dropped
  assign hs = o_host_ready && i_host_valid && !i_abort;
  assign last = {1'b0, idx_q} == cnt_q - (AW+1)'(1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    drn_d = drn_q;
    err_d = err_q;
    wen_d = hs;
    addr_d = hs ? idx_q : addr_q;
    wdata_d = hs ? i_host_data : wdata_q;
    case (state_q)
      IDLE, RUN: begin
        if (i_start && start_ok) begin
          state_d = LOAD;
          cnt_d = i_wcount;
          idx_d = '0;
          err_d = (state_q == IDLE) ? 1'b0 : err_q;
        end else if (i_start) begin
          err_d = 1'b1;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else if (i_host_valid) begin
          state_d = last ? DRAIN : LOAD;
          drn_d = 1'b0;
          idx_d = last ? idx_q : idx_q + AW'(1);
        end
      end
      default: begin
        if (i_abort) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else begin
          state_d = drn_q ? RUN : DRAIN;
          drn_d = 1'b1;
        end
      end
    endcase
    done_d = (state_q == DRAIN) && (state_d == RUN);
    crn_d = state_d == RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      drn_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      crn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wen_q <= wen_d;
      drn_q <= drn_d;
      done_q <= done_d;
      err_q <= err_d;
      crn_q <= crn_d;
    end
  end
  assign o_im_wen = {4{wen_q}};
  assign o_im_addr = addr_q;
  assign o_im_wdata = wdata_q;
  assign o_core_rst_n = crn_q;
  assign o_done = done_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_im_loader_ctrl.sv
// tb_im_loader_ctrl: scoreboard bench; driver predicts writes/done cycles, monitor pops and compares.
module tb_im_loader_ctrl;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic rst, i_start, i_abort, i_host_valid;
  logic [AW:0] i_wcount;
  logic [31:0] i_host_data;
  logic o_host_ready, o_core_rst_n, o_busy, o_done, o_err;
  logic [3:0] o_im_wen;
  logic [AW-1:0] o_im_addr;
  logic [31:0] o_im_wdata;
  im_loader_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_wcount(i_wcount), .i_abort(i_abort),
    .i_host_valid(i_host_valid), .i_host_data(i_host_data), .o_host_ready(o_host_ready),
    .o_im_wen(o_im_wen), .o_im_addr(o_im_addr), .o_im_wdata(o_im_wdata),
    .o_core_rst_n(o_core_rst_n), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [AW-1:0] a; logic [31:0] d; int c;} wr_t;
  wr_t wq[$];
  int dq[$];
  int cyc = 0;
  int passed = 0, total = 0;
  int m_idx, m_cnt;
  logic m_err, m_run;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask
  // monitor: every write and done pulse must match the oldest prediction
  wr_t e;
  always @(negedge clk) if (!rst) begin
    if (o_im_wen != 4'h0) begin
      if (wq.size() == 0) chk("spurious_wen", o_im_wen, 4'h0);
      else begin
        e = wq.pop_front();
        chk("wen", o_im_wen, 4'hF);
        chk("addr", o_im_addr, e.a);
        chk("wdata", o_im_wdata, e.d);
        chk("write_cycle", cyc, e.c);
      end
    end
    if (o_done) begin
      if (dq.size() == 0) chk("spurious_done", o_done, 1'b0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_idx = 0; m_cnt = 0; m_err = 1'b0; m_run = 1'b0;
    wq.delete();
    dq.delete();
  endtask
  task automatic start(input int n);
    i_start = 1'b1;
    i_wcount = n[AW:0];
    tick();
    i_start = 1'b0;
    if (n >= 1 && n <= DEPTH) begin
      m_idx = 0; m_cnt = n;
      if (!m_run) m_err = 1'b0;
      m_run = 1'b0;
    end else m_err = 1'b1;
  endtask
  task automatic word(input int gap);
    logic [31:0] d;
    d = $urandom;
    repeat (gap) tick();
    i_host_valid = 1'b1;
    i_host_data = d;
    wq.push_back('{a: m_idx[AW-1:0], d: d, c: cyc + 1});
    if (m_idx == m_cnt - 1) dq.push_back(cyc + 3);
    chk("host_ready", o_host_ready, 1'b1);
    chk("busy", o_busy, 1'b1);
    tick();
    i_host_valid = 1'b0;
    m_idx++;
  endtask
  task automatic wait_done();
    int k;
    k = 0;
    while (dq.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk("done_pending", dq.size(), 0);
    tick();
    m_run = 1'b1;
    chk("core_rst_n_run", o_core_rst_n, m_run);
    chk("busy_run", o_busy, 1'b0);
    chk("err_run", o_err, m_err);
    chk("writes_pending", wq.size(), 0);
  endtask
  task automatic idle_checks(input string nm);
    chk({nm, "_err"}, o_err, m_err);
    chk({nm, "_busy"}, o_busy, 1'b0);
    chk({nm, "_ready"}, o_host_ready, 1'b0);
    chk({nm, "_core_rst_n"}, o_core_rst_n, 1'b0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_host_valid = 1'b0;
    i_wcount = '0; i_host_data = '0;
    tick();
    chk("rst_wen", o_im_wen, 4'h0);
    chk("rst_addr", o_im_addr, '0);
    chk("rst_wdata", o_im_wdata, 32'h0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_err, 1'b0);
    do_reset();
    idle_checks("rst");
    // rejected starts leave the block idle with the error flag up
    start(0);
    tick();
    idle_checks("wc0");
    do_reset();
    start(DEPTH + 1);
    repeat (3) tick();
    idle_checks("wcbig");
    // three back-to-back words
    start(3);
    for (int i = 0; i < 3; i++) word(0);
    chk("busy_drain", o_busy, 1'b1);
    wait_done();
    // reload from RUN with a single word
    start(1);
    chk("reload_core_rst_n", o_core_rst_n, 1'b0);
    word(1);
    wait_done();
    // abort coincident with the third word
    start(4);
    word(0);
    word(0);
    i_host_valid = 1'b1; i_abort = 1'b1; i_host_data = $urandom;
    tick();
    i_host_valid = 1'b0; i_abort = 1'b0;
    m_err = 1'b1; m_run = 1'b0;
    repeat (3) tick();
    idle_checks("abort");
    chk("abort_writes_left", wq.size(), 0);
    // full depth with gapped valid, then valid in RUN must not write
    start(DEPTH);
    for (int i = 0; i < DEPTH; i++) word($urandom_range(0, 2));
    wait_done();
    i_host_valid = 1'b1;
    repeat (4) tick();
    i_host_valid = 1'b0;
    chk("no_wrap_core_rst_n", o_core_rst_n, 1'b1);
    // asynchronous reset between edges while a write is pending
    start(5);
    word(0);
    tick();
    i_host_valid = 1'b1; i_host_data = $urandom;
    tick();
    #2 rst = 1'b1;
    #1;
    m_idx = 0; m_cnt = 0; m_err = 1'b0; m_run = 1'b0;
    chk("arst_wen", o_im_wen, 4'h0);
    chk("arst_addr", o_im_addr, '0);
    chk("arst_wdata", o_im_wdata, 32'h0);
    chk("arst_done", o_done, 1'b0);
    idle_checks("arst");
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) tick();
    i_host_valid = 1'b0;
    idle_checks("post_rst");
    chk("final_writes", wq.size(), 0);
    chk("final_done", dq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
